// File: rtl/rast_pkg.sv
// Shared rasterizer-feeder definitions: opcodes, widths, FSM encodings, triangle record layout.
// Fixed 32-bit command packing: vertex word {y[15:0],x[15:0]}, colour word {8'h00,r,g,b}.
package rast_pkg;
    localparam int CMD_W   = 32;
    localparam int COORD_W = 16;
    localparam int COLOR_W = 24;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_TRI = 8'h01;

    localparam int VX_LSB  = 0;
    localparam int VY_LSB  = 16;
    localparam int COL_LSB = 0;
    localparam int OPC_LSB = 24;

    typedef enum logic [3:0] {
        C_HDR = 4'h0,
        C_V0  = 4'h1,
        C_V1  = 4'h2,
        C_V2  = 4'h3,
        C_COL = 4'h4
    } collect_state_t;

    typedef enum logic [3:0] {
        H_IDLE  = 4'h0,
        H_OFFER = 4'h1,
        H_HELD  = 4'h2
    } hs_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [COLOR_W-1:0] color;
    } tri_rec_t;

    function automatic logic [7:0] opcode_of(input logic [CMD_W-1:0] word);
        return word[OPC_LSB +: 8];
    endfunction
endpackage

// File: rtl/triangle_loader_if.sv
// Command word stream from the HPS bridge: valid/ready, word taken when both are high.
interface triangle_loader_if;
    import rast_pkg::*;

    logic             cmd_valid;
    logic [CMD_W-1:0] cmd_data;
    logic             cmd_ready;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/rast_handshake.sv
// Output buffer + level handshake to the rasterizer: load from a full upstream buffer when empty,
// raise data_ready the cycle after the load, drop it on busy, release the buffer when busy falls.
module rast_handshake
    import rast_pkg::*;
(
    input  logic     clock,
    input  logic     reset_n,
    input  logic     load_req,
    input  tri_rec_t rec_in,
    output logic     load,
    input  logic     busy,
    output logic     data_ready,
    output tri_rec_t rec_out
);
    hs_state_t state, state_nxt;
    logic      data_ready_nxt;

    always_comb begin
        state_nxt      = state;
        data_ready_nxt = data_ready;
        load           = 1'b0;
        case (state)
            H_IDLE: begin
                if (load_req) begin
                    load      = 1'b1;
                    state_nxt = H_OFFER;
                end
            end
            H_OFFER: begin
                // Offer only while busy is low so data_ready never rises under busy.
                if (data_ready && busy) begin
                    state_nxt      = H_HELD;
                    data_ready_nxt = 1'b0;
                end else if (!busy) begin
                    data_ready_nxt = 1'b1;
                end
            end
            H_HELD: begin
                if (!busy) state_nxt = H_IDLE;
            end
            default: begin
                state_nxt      = H_IDLE;
                data_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= H_IDLE;
            data_ready <= 1'b0;
            rec_out    <= '0;
        end else begin
            state      <= state_nxt;
            data_ready <= data_ready_nxt;
            if (load) rec_out <= rec_in;
        end
    end
endmodule

// File: rtl/triangle_loader.sv
// Assembles 5-word triangle commands into a collect buffer, hands them to rast_handshake; data_ready
// two cycles after the last word. Stalls input via cmd_ready while full. TRIANGLE_LOADER_STATS_EN adds counters.
module triangle_loader
    import rast_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    triangle_loader_if.slave   cmd,
    input  logic               busy,
    output logic               data_ready,
    output logic [COORD_W-1:0] tri_x0,
    output logic [COORD_W-1:0] tri_y0,
    output logic [COORD_W-1:0] tri_x1,
    output logic [COORD_W-1:0] tri_y1,
    output logic [COORD_W-1:0] tri_x2,
    output logic [COORD_W-1:0] tri_y2,
    output logic [COLOR_W-1:0] tri_color,
    output logic               bad_cmd
`ifdef TRIANGLE_LOADER_STATS_EN
    ,
    output logic [31:0]        tri_count,
    output logic [15:0]        bad_count
`endif
);
    collect_state_t c_state, c_state_nxt;
    tri_rec_t       col_rec, out_rec;
    logic           collect_full, rdy_en, accept, load, bad_nxt;
    logic [7:0]     opcode;

    // rdy_en keeps cmd_ready low through reset and sets on the first clock after release.
    assign cmd.cmd_ready = rdy_en & ~collect_full;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign opcode        = opcode_of(cmd.cmd_data);

    always_comb begin
        c_state_nxt = c_state;
        bad_nxt     = 1'b0;
        if (accept) begin
            case (c_state)
                C_HDR: begin
                    if (opcode == OP_TRI)      c_state_nxt = C_V0;
                    else if (opcode != OP_NOP) bad_nxt     = 1'b1;
                end
                C_V0:    c_state_nxt = C_V1;
                C_V1:    c_state_nxt = C_V2;
                C_V2:    c_state_nxt = C_COL;
                C_COL:   c_state_nxt = C_HDR;
                default: c_state_nxt = C_HDR;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c_state      <= C_HDR;
            rdy_en       <= 1'b0;
            bad_cmd      <= 1'b0;
            collect_full <= 1'b0;
        end else begin
            c_state <= c_state_nxt;
            rdy_en  <= 1'b1;
            bad_cmd <= bad_nxt;
            if (load)                           collect_full <= 1'b0;
            else if (accept && c_state == C_COL) collect_full <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_rec <= '0;
        end else if (accept) begin
            case (c_state)
                C_V0: begin
                    col_rec.x0 <= cmd.cmd_data[VX_LSB +: COORD_W];
                    col_rec.y0 <= cmd.cmd_data[VY_LSB +: COORD_W];
                end
                C_V1: begin
                    col_rec.x1 <= cmd.cmd_data[VX_LSB +: COORD_W];
                    col_rec.y1 <= cmd.cmd_data[VY_LSB +: COORD_W];
                end
                C_V2: begin
                    col_rec.x2 <= cmd.cmd_data[VX_LSB +: COORD_W];
                    col_rec.y2 <= cmd.cmd_data[VY_LSB +: COORD_W];
                end
                C_COL:   col_rec.color <= cmd.cmd_data[COL_LSB +: COLOR_W];
                default: col_rec <= col_rec;
            endcase
        end
    end

    rast_handshake u_hs (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_req   (collect_full),
        .rec_in     (col_rec),
        .load       (load),
        .busy       (busy),
        .data_ready (data_ready),
        .rec_out    (out_rec)
    );

    assign tri_x0    = out_rec.x0;
    assign tri_y0    = out_rec.y0;
    assign tri_x1    = out_rec.x1;
    assign tri_y1    = out_rec.y1;
    assign tri_x2    = out_rec.x2;
    assign tri_y2    = out_rec.y2;
    assign tri_color = out_rec.color;

`ifdef TRIANGLE_LOADER_STATS_EN
    // data_ready is only high in the offer state, so data_ready & busy is the take event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tri_count <= 32'd0;
            bad_count <= 16'd0;
        end else begin
            if (data_ready && busy)                tri_count <= tri_count + 32'd1;
            if (bad_cmd && bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_triangle_loader.sv
// Directed + randomised stimulus; a queue of expected triangle records is checked on every data_ready rise.
module tb_triangle_loader;
    logic        clock;
    logic        reset_n;
    logic        busy;
    logic        data_ready;
    logic [15:0] tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2;
    logic [23:0] tri_color;
    logic        bad_cmd;
`ifdef TRIANGLE_LOADER_STATS_EN
    logic [31:0] tri_count;
    logic [15:0] bad_count;
`endif

    triangle_loader_if cmd_if();

    triangle_loader dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd        (cmd_if),
        .busy       (busy),
        .data_ready (data_ready),
        .tri_x0     (tri_x0),
        .tri_y0     (tri_y0),
        .tri_x1     (tri_x1),
        .tri_y1     (tri_y1),
        .tri_x2     (tri_x2),
        .tri_y2     (tri_y2),
        .tri_color  (tri_color),
        .bad_cmd    (bad_cmd)
`ifdef TRIANGLE_LOADER_STATS_EN
        ,
        .tri_count  (tri_count),
        .bad_count  (bad_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_chk = 0;
    int n_pass = 0;
    int rises = 0;
    int bad_seen = 0;
    int exp_bad = 0;
    logic [119:0] exp_q[$];

    bit rast_en = 1'b1;
    bit rand_mode = 1'b0;
    int hold_cycles = 3;
    int idle_pct = 0;

    task automatic chk(input bit ok, input string name, input logic [119:0] act, input logic [119:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [119:0] rec_now();
        return {tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2, tri_color};
    endfunction

    // Rasterizer model: sees data_ready, raises busy after a delay, holds it, drops it.
    initial begin
        int d, h;
        busy = 1'b0;
        forever begin
            @(posedge clock); #2;
            if (rast_en && reset_n && data_ready && !busy) begin
                d = rand_mode ? int'($urandom_range(3)) : 0;
                h = rand_mode ? int'($urandom_range(6, 1)) : hold_cycles;
                repeat (d) begin @(posedge clock); #2; end
                busy = 1'b1;
                repeat (h) begin @(posedge clock); #2; end
                busy = 1'b0;
            end
        end
    end

    // Compare process: record order/content at each offer, hold stability, pulse widths.
    initial begin
        logic         prev_dr, prev_busy, prev_bad, in_win;
        logic [119:0] held, cur, e;
        prev_dr = 0; prev_busy = 0; prev_bad = 0; in_win = 0; held = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_dr = 0; prev_busy = 0; prev_bad = 0; in_win = 0;
                continue;
            end
            cur = rec_now();
            if (data_ready && !prev_dr) begin
                chk(!prev_busy, "dr_rise_under_busy", prev_busy, 0);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_record", cur, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(cur == e, "record", cur, e);
                end
                rises++;
                in_win = 1;
                held = cur;
            end else if (in_win) begin
                chk(cur == held, "tri_hold", cur, held);
                if (prev_busy && !busy && !data_ready) in_win = 0;
            end
            if (bad_cmd) begin
                bad_seen++;
                chk(!prev_bad, "bad_pulse_width", prev_bad, 0);
            end
            prev_dr = data_ready; prev_busy = busy; prev_bad = bad_cmd;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    // All drive tasks start and end at posedge+2.
    task automatic send_word(input logic [31:0] w);
        int guard = 0;
        if (idle_pct > 0)
            while (int'($urandom_range(99)) < idle_pct) begin @(posedge clock); #2; end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = w;
        while (!cmd_if.cmd_ready && guard < 2000) begin @(posedge clock); #2; guard++; end
        if (!cmd_if.cmd_ready) chk(1'b0, "cmd_ready_timeout", guard, 2000);
        @(posedge clock); #2;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic send_tri(input logic [15:0] x0, y0, x1, y1, x2, y2, input logic [23:0] col);
        exp_q.push_back({x0, y0, x1, y1, x2, y2, col});
        send_word(32'h0100_0000);
        send_word({y0, x0});
        send_word({y1, x1});
        send_word({y2, x2});
        send_word({8'h00, col});
    endtask

    task automatic wait_idle(input int lim, input string name);
        int i = 0;
        while ((exp_q.size() != 0 || data_ready || busy) && i < lim) begin @(posedge clock); #2; i++; end
        chk(i < lim, name, i, lim);
        repeat (3) begin @(posedge clock); #2; end
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        reset_n = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        repeat (2) begin @(posedge clock); #2; end
        reset_n = 1'b1;
        @(posedge clock); #2;
    endtask

    initial begin
        int r0;
        logic [15:0] rx[6];
        reset_n = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = '0;
        #3 reset_n = 1'b0;
        @(posedge clock); #2;
        chk(cmd_if.cmd_ready == 1'b0, "rst_cmd_ready", cmd_if.cmd_ready, 0);
        chk(data_ready == 1'b0, "rst_data_ready", data_ready, 0);
        chk(bad_cmd == 1'b0, "rst_bad_cmd", bad_cmd, 0);
        chk(rec_now() == '0, "rst_tri", rec_now(), 0);
        repeat (2) begin @(posedge clock); #2; end
        reset_n = 1'b1;
        @(posedge clock); #2;
        chk(cmd_if.cmd_ready == 1'b1, "first_cycle_ready", cmd_if.cmd_ready, 1);

        // 1: single triangle, latency and literal field values
        hold_cycles = 3;
        send_tri(16'd3, 16'd5, 16'd20, 16'd10, 16'd1, 16'd20, 24'hFF8040);
        chk(data_ready == 1'b0, "lat_n", data_ready, 0);
        @(posedge clock); #2;
        chk(data_ready == 1'b0, "lat_n1", data_ready, 0);
        @(posedge clock); #2;
        chk(data_ready == 1'b1, "lat_n2", data_ready, 1);
        chk(tri_x0 == 16'd3 && tri_y0 == 16'd5, "t1_v0", {tri_y0, tri_x0}, {16'd5, 16'd3});
        chk(tri_x1 == 16'd20 && tri_y1 == 16'd10, "t1_v1", {tri_y1, tri_x1}, {16'd10, 16'd20});
        chk(tri_x2 == 16'd1 && tri_y2 == 16'd20, "t1_v2", {tri_y2, tri_x2}, {16'd20, 16'd1});
        chk(tri_color == 24'hFF8040, "t1_color", tri_color, 24'hFF8040);
        wait_idle(200, "t1_idle");

        // 2: back-to-back with a long busy
        do_reset();
        hold_cycles = 100;
        r0 = rises;
        send_tri(16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h1234, 16'hABCD, 24'h000001);
        send_tri(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 24'h123456);
        chk(cmd_if.cmd_ready == 1'b0, "t2_ready_drops", cmd_if.cmd_ready, 0);
        chk(data_ready == 1'b0, "t2_no_offer_while_busy", data_ready, 0);
        chk(busy == 1'b1, "t2_busy_active", busy, 1);
        wait_idle(1000, "t2_idle");
        chk(rises - r0 == 2, "t2_offers", rises - r0, 2);

        // 3: unknown opcode and a NOP between triangles
        do_reset();
        hold_cycles = 4;
        send_tri(16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 24'hA5A5A5);
        send_word(32'h7E12_3456);
        exp_bad++;
        chk(bad_cmd == 1'b1, "bad_pulse_on", bad_cmd, 1);
        @(posedge clock); #2;
        chk(bad_cmd == 1'b0, "bad_pulse_off", bad_cmd, 0);
        send_word(32'h0000_0000);
        send_tri(16'hFFF0, 16'd100, 16'd200, 16'hFF00, 16'd0, 16'd1, 24'h00FF00);
        wait_idle(500, "t3_idle");
`ifdef TRIANGLE_LOADER_STATS_EN
        chk(bad_count == 16'd1, "stats_bad_count", bad_count, 1);
        chk(tri_count == 32'd2, "stats_tri_count", tri_count, 2);
`endif

        // 4: reset mid-triangle while an offer is pending
        rast_en = 1'b0;
        r0 = 0;
        send_tri(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 24'h010203);
        while (!data_ready && r0 < 50) begin @(posedge clock); #2; r0++; end
        chk(data_ready == 1'b1, "t4_offer_pending", data_ready, 1);
        send_word(32'h0100_0000);
        send_word(32'h0009_0009);
        send_word(32'h0008_0008);
        reset_n = 1'b0;
        #1;
        chk(data_ready == 1'b0, "t4_dr_in_reset", data_ready, 0);
        chk(cmd_if.cmd_ready == 1'b0, "t4_ready_in_reset", cmd_if.cmd_ready, 0);
        chk(rec_now() == '0, "t4_tri_cleared", rec_now(), 0);
        exp_q.delete();
        @(posedge clock); #2;
        chk(data_ready == 1'b0, "t4_dr_held_low", data_ready, 0);
        reset_n = 1'b1;
        rast_en = 1'b1;
        @(posedge clock); #2;
        r0 = rises;
        send_tri(16'd40, 16'd41, 16'd42, 16'd43, 16'd44, 16'd45, 24'hC0FFEE);
        wait_idle(200, "t4_idle");
        chk(rises - r0 == 1, "t4_only_new", rises - r0, 1);

        // 5: random gaps and rasterizer timing, 200 triangles
        rand_mode = 1'b1;
        idle_pct = 30;
        r0 = rises;
        for (int t = 0; t < 200; t++) begin
            for (int k = 0; k < 6; k++) rx[k] = 16'($urandom);
            send_tri(rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], 24'($urandom));
        end
        wait_idle(5000, "t5_idle");
        chk(rises - r0 == 200, "t5_offers", rises - r0, 200);

        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        chk(bad_seen == exp_bad, "bad_pulses", bad_seen, exp_bad);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
